// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the decoder.
// Holds the PC and fetches one word per request from instruction memory using
// a req/ready handshake. The word is presented to the decoder as ir with a
// valid/ready handshake. When the decoder accepts ir, the next PC is chosen
// from the pc_ctrl code.
// Optional feature: define FETCH_TIMEOUT_EN to abandon a stalled fetch after
// TIMEOUT_CYCLES request cycles. The unit then parks in a sticky error state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic [1:0]  pc_ctrl,
  input  logic        branch_taken,
  input  logic [31:0] branch_imm,
  input  logic [31:0] reg_target,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        fetch_done;
  logic        accept;
  logic        timeout_hit;

  assign pc_plus4   = pc + 32'd4;
  assign link_addr  = pc_plus4;
  assign imem_addr  = pc;
  assign fetch_done = (state == REQ) && imem_ready;
  assign accept     = (state == VALID) && ir_ready;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] timeout_cnt;

  // A fetch times out on the request cycle that would bring the count to the limit.
  assign timeout_hit = (state == REQ) && !imem_ready &&
                       ((timeout_cnt + 32'd1) == TIMEOUT_CYCLES);
  assign fetch_err   = (state == ERR);

  // Count consecutive unanswered request cycles; clear on any answer or state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= 32'd0;
    end else if ((state == REQ) && !imem_ready && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + 32'd1;
    end else begin
      timeout_cnt <= 32'd0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Next-PC selection; only consumed on the accept cycle, wraps at 32 bits.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_ctrl)
      2'd0: next_pc = pc_plus4;
      2'd1: next_pc = branch_taken ? (pc_plus4 + {branch_imm[29:0], 2'b00}) : pc_plus4;
      2'd2: next_pc = reg_target;
      2'd3: next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

  // State register; reset abandons any in-flight request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_valid   = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_next = VALID;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      VALID: begin
        ir_valid = 1'b1;
        if (ir_ready) begin
          state_next = REQ;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the instruction word and advance the PC on the handshake edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= 32'd0;
      pc <= RESET_PC;
    end else begin
      if (fetch_done) begin
        ir <= imem_rdata;
      end
      if (accept) begin
        pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit.
// It walks through the reset state, the first fetch, every pc_ctrl mode,
// fetch and accept stalls, a misaligned target, resets in the middle of a
// transfer, and the timeout behaviour for the build in use.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [1:0]  pc_ctrl;
  logic        branch_taken;
  logic [31:0] branch_imm;
  logic [31:0] reg_target;
  logic        fetch_err;

  int total;
  int bad;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .pc           (pc),
    .link_addr    (link_addr),
    .pc_ctrl      (pc_ctrl),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .reg_target   (reg_target),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ctrl, input logic taken,
                               input logic [31:0] imm, input logic [31:0] target);
    pc_ctrl      = ctrl;
    branch_taken = taken;
    branch_imm   = imm;
    reg_target   = target;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchWord(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    stepClk();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic acceptIr(input logic [1:0] ctrl, input logic taken,
                          input logic [31:0] imm, input logic [31:0] target);
    applyStimulus(ctrl, taken, imm, target);
    ir_ready = 1'b1;
    stepClk();
    ir_ready = 1'b0;
    applyStimulus(2'd2, 1'b1, 32'h0000_0100, 32'h7777_7770);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    ir_ready   = 1'b0;
    applyStimulus(2'd0, 1'b0, 32'd0, 32'd0);
    repeat (2) stepClk();

    // reset state
    checkOutput("rst_pc",       pc,                32'h0);
    checkOutput("rst_ir",       ir,                32'h0);
    checkOutput("rst_ir_valid", 32'(ir_valid),     32'd0);
    checkOutput("rst_req",      32'(imem_req),     32'd0);
    checkOutput("rst_err",      32'(fetch_err),    32'd0);
    checkOutput("rst_link",     link_addr,         32'h4);

    // first fetch
    rst_n = 1'b1;
    stepClk();
    checkOutput("first_req",      32'(imem_req),  32'd1);
    checkOutput("first_addr",     imem_addr,      32'h0);
    checkOutput("first_ir_valid", 32'(ir_valid),  32'd0);
    fetchWord(32'h2008_0005);
    checkOutput("first_ir",    ir,             32'h2008_0005);
    checkOutput("first_valid", 32'(ir_valid),  32'd1);
    checkOutput("first_noreq", 32'(imem_req),  32'd0);
    checkOutput("first_pc",    pc,             32'h0);
    acceptIr(2'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("seq_pc",    pc,            32'h4);
    checkOutput("seq_req",   32'(imem_req), 32'd1);
    checkOutput("seq_addr",  imem_addr,     32'h4);
    checkOutput("seq_inval", 32'(ir_valid), 32'd0);
    checkOutput("seq_link",  link_addr,     32'h8);

    // register target
    fetchWord(32'h0000_0008);
    acceptIr(2'd2, 1'b0, 32'd0, 32'h0000_0040);
    checkOutput("jr_pc",   pc,        32'h40);
    checkOutput("jr_link", link_addr, 32'h44);

    // taken branch with negative offset from 0x10
    fetchWord(32'h0000_0008);
    acceptIr(2'd2, 1'b0, 32'd0, 32'h0000_0010);
    checkOutput("pc_at_10", pc, 32'h10);
    fetchWord(32'h1000_FFFF);
    acceptIr(2'd1, 1'b1, 32'hFFFF_FFFC, 32'd0);
    checkOutput("br_taken_pc", pc,        32'h04);
    checkOutput("br_link",     link_addr, 32'h08);

    // not-taken branch from 0x10
    fetchWord(32'h0000_0008);
    acceptIr(2'd2, 1'b0, 32'd0, 32'h0000_0010);
    fetchWord(32'h1000_FFFF);
    acceptIr(2'd1, 1'b0, 32'hFFFF_FFFC, 32'd0);
    checkOutput("br_not_taken_pc", pc, 32'h14);

    // jump from 0x1000_0000
    fetchWord(32'h0000_0008);
    acceptIr(2'd2, 1'b0, 32'd0, 32'h1000_0000);
    fetchWord(32'h0800_0010);
    checkOutput("j_ir", ir, 32'h0800_0010);
    acceptIr(2'd3, 1'b0, 32'd0, 32'd0);
    checkOutput("j_pc",   pc,        32'h1000_0040);
    checkOutput("j_link", link_addr, 32'h1000_0044);

    // taken branch with positive offset
    fetchWord(32'h1000_0010);
    acceptIr(2'd1, 1'b1, 32'h0000_0010, 32'd0);
    checkOutput("br_pos_pc", pc, 32'h1000_0084);

    // wrap-around at the top of the address space
    fetchWord(32'h0000_0008);
    acceptIr(2'd2, 1'b0, 32'd0, 32'hFFFF_FFFC);
    checkOutput("wrap_link", link_addr, 32'h0);
    fetchWord(32'h0000_0000);
    acceptIr(2'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("wrap_pc", pc, 32'h0);

    // memory stall: request held stable
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("stall_req",   32'(imem_req), 32'd1);
      checkOutput("stall_addr",  imem_addr,     32'h0);
      checkOutput("stall_inval", 32'(ir_valid), 32'd0);
    end

    // decoder stall: ir and pc held, stray imem_ready and next-pc inputs ignored
    fetchWord(32'h1234_5678);
    applyStimulus(2'd2, 1'b1, 32'h0000_0100, 32'hAAAA_AAA8);
    imem_ready = 1'b1;
    imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("hold_ir",    ir,            32'h1234_5678);
      checkOutput("hold_pc",    pc,            32'h0);
      checkOutput("hold_noreq", 32'(imem_req), 32'd0);
      checkOutput("hold_valid", 32'(ir_valid), 32'd1);
    end
    imem_ready = 1'b0;

    // misaligned target fetched as-is
    acceptIr(2'd2, 1'b0, 32'd0, 32'h0000_0103);
    checkOutput("mis_pc",   pc,            32'h103);
    checkOutput("mis_addr", imem_addr,     32'h103);
    checkOutput("mis_req",  32'(imem_req), 32'd1);

    // reset in the middle of a request
    rst_n = 1'b0;
    #1;
    checkOutput("rreq_req", 32'(imem_req), 32'd0);
    checkOutput("rreq_pc",  pc,            32'h0);
    stepClk();
    rst_n = 1'b1;
    stepClk();
    checkOutput("rreq_restart_req",  32'(imem_req), 32'd1);
    checkOutput("rreq_restart_addr", imem_addr,     32'h0);

    // reset while an instruction is waiting for the decoder
    fetchWord(32'hCAFE_0001);
    checkOutput("rval_pre", 32'(ir_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rval_valid", 32'(ir_valid), 32'd0);
    checkOutput("rval_ir",    ir,            32'h0);
    stepClk();
    rst_n = 1'b1;
    stepClk();
    checkOutput("rval_restart_req", 32'(imem_req), 32'd1);

    // long memory stall
`ifdef FETCH_TIMEOUT_EN
    repeat (15) stepClk();
    checkOutput("to_before_req", 32'(imem_req),  32'd1);
    checkOutput("to_before_err", 32'(fetch_err), 32'd0);
    stepClk();
    checkOutput("to_err",   32'(fetch_err), 32'd1);
    checkOutput("to_noreq", 32'(imem_req),  32'd0);
    checkOutput("to_inval", 32'(ir_valid),  32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h0BAD_0BAD;
    repeat (3) stepClk();
    imem_ready = 1'b0;
    checkOutput("to_sticky_err",   32'(fetch_err), 32'd1);
    checkOutput("to_sticky_inval", 32'(ir_valid),  32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("to_rst_err", 32'(fetch_err), 32'd0);
    stepClk();
    rst_n = 1'b1;
    stepClk();
`else
    repeat (20) stepClk();
    checkOutput("nto_req",  32'(imem_req),  32'd1);
    checkOutput("nto_err",  32'(fetch_err), 32'd0);
    checkOutput("nto_addr", imem_addr,      32'h0);
    fetchWord(32'h0000_0ABC);
    checkOutput("nto_ir", ir, 32'h0000_0ABC);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
